// File: rtl/sargantana_hpdc_pkg.sv
// Shared HPDCache memory-interface types and the read-arbiter configuration.
package sargantana_hpdc_pkg;

  localparam int unsigned HPDCACHE_MEM_ADDR_WIDTH  = 32;
  localparam int unsigned HPDCACHE_MEM_DATA_WIDTH  = 64;
  localparam int unsigned HPDCACHE_MEM_TID_WIDTH   = 8;
  localparam int unsigned HPDCACHE_MEM_RD_ARB_NREQ = 2;

  typedef logic [HPDCACHE_MEM_TID_WIDTH-1:0] hpdcache_mem_id_t;

  typedef struct packed {
    logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] mem_req_addr;
    logic [7:0]                         mem_req_len;
    logic [2:0]                         mem_req_size;
    hpdcache_mem_id_t                   mem_req_id;
    logic                               mem_req_cacheable;
  } hpdcache_mem_req_t;

  typedef struct packed {
    logic [1:0]                         mem_resp_r_error;
    hpdcache_mem_id_t                   mem_resp_r_id;
    logic [HPDCACHE_MEM_DATA_WIDTH-1:0] mem_resp_r_data;
    logic                               mem_resp_r_last;
  } hpdcache_mem_resp_r_t;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } hpdc_mem_rd_arb_state_e;

endpackage

// File: rtl/hpdc_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping modulo N.
module hpdc_rr_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    logic [IDX_W-1:0] j;
    j       = '0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IDX_W'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = j;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpdc_mem_rd_arbiter.sv
// Round-robin sharing of one HPDCache memory read channel with ID tagging and per-requester
// outstanding caps. Define HPDC_MEM_RD_ARB_CHECK_EN to add the sticky protocol error output err_o.
module hpdc_mem_rd_arbiter
  import sargantana_hpdc_pkg::*;
#(
  parameter  int unsigned NREQ     = HPDCACHE_MEM_RD_ARB_NREQ,
  parameter  int unsigned MAX_OUT  = 4,
  localparam int unsigned IDX_W    = $clog2(NREQ),
  localparam int unsigned UP_TID_W = HPDCACHE_MEM_TID_WIDTH - IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      up_req_valid_i,
  output logic [NREQ-1:0]      up_req_ready_o,
  input  hpdcache_mem_req_t    up_req_i [NREQ],
  output logic [NREQ-1:0]      up_resp_valid_o,
  input  logic [NREQ-1:0]      up_resp_ready_i,
  output hpdcache_mem_resp_r_t up_resp_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output hpdcache_mem_req_t    mem_req_o,
  input  logic                 mem_resp_valid_i,
  output logic                 mem_resp_ready_o,
  input  hpdcache_mem_resp_r_t mem_resp_i
`ifdef HPDC_MEM_RD_ARB_CHECK_EN
  ,
  output logic                 err_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  hpdc_mem_rd_arb_state_e state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, hold_idx_q, hold_idx_d;
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  logic [NREQ-1:0]  elig, pick_gnt, win_oh;
  logic [IDX_W-1:0] pick_idx, win_idx, resp_idx, next_ptr;
  logic             pick_valid, win_valid, req_hs, resp_in_range, resp_hs;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = up_req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  hpdc_rr_picker #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // In HOLD the latched winner overrides the picker; outputs are gated while reset is asserted.
  always_comb begin
    win_oh = '0;
    if (state_q == HOLD) begin
      win_idx           = hold_idx_q;
      win_valid         = 1'b1;
      win_oh[hold_idx_q] = 1'b1;
    end else begin
      win_idx   = pick_idx;
      win_valid = pick_valid;
      win_oh    = pick_gnt;
    end
    mem_req_o            = up_req_i[win_idx];
    mem_req_o.mem_req_id = {win_idx, up_req_i[win_idx].mem_req_id[UP_TID_W-1:0]};
    mem_req_valid_o      = win_valid & ~rst_i;
    req_hs               = mem_req_valid_o & mem_req_ready_i;
    up_req_ready_o       = req_hs ? win_oh : '0;
    next_ptr             = IDX_W'((32'(win_idx) + 32'd1) % NREQ);
  end

  always_comb begin
    resp_idx      = mem_resp_i.mem_resp_r_id[HPDCACHE_MEM_TID_WIDTH-1 -: IDX_W];
    resp_in_range = (32'(resp_idx) < NREQ);
    up_resp_o     = mem_resp_i;
    up_resp_o.mem_resp_r_id[HPDCACHE_MEM_TID_WIDTH-1 -: IDX_W] = '0;
    up_resp_valid_o  = '0;
    mem_resp_ready_o = 1'b0;
    if (!rst_i) begin
      if (resp_in_range) begin
        up_resp_valid_o[resp_idx] = mem_resp_valid_i;
        mem_resp_ready_o          = up_resp_ready_i[resp_idx];
      end else begin
        mem_resp_ready_o = 1'b1;
      end
    end
    resp_hs = mem_resp_valid_i & mem_resp_ready_o;
  end

  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      inc      = up_req_ready_o[i];
      dec      = resp_hs && resp_in_range && mem_resp_i.mem_resp_r_last && (32'(resp_idx) == i);
      if (inc && !dec && (cnt_q[i] != CNT_W'(MAX_OUT))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_idx_d = hold_idx_q;
    if (req_hs) begin
      rr_ptr_d = next_ptr;
      state_d  = ARB;
    end else if ((state_q == ARB) && pick_valid) begin
      hold_idx_d = pick_idx;
      state_d    = HOLD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      hold_idx_q <= '0;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_idx_q <= hold_idx_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef HPDC_MEM_RD_ARB_CHECK_EN
  hpdcache_mem_req_t hold_req_q;
  logic              err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_req_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ARB) hold_req_q <= mem_req_o;
      if ((mem_resp_valid_i && resp_in_range && (cnt_q[resp_idx] == '0)) ||
          (mem_resp_valid_i && !resp_in_range) ||
          ((state_q == HOLD) && (mem_req_o != hold_req_q))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`endif

`ifndef SYNTHESIS
  hold_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == HOLD) |-> ($stable(mem_req_o) && up_req_valid_i[hold_idx_q]));
`endif

endmodule

// File: tb/tb_hpdc_mem_rd_arbiter.sv
// Self-checking bench for hpdc_mem_rd_arbiter: directed scenarios plus random traffic vs a reference model.
`timescale 1ns/1ps
module tb_hpdc_mem_rd_arbiter;
  import sargantana_hpdc_pkg::*;

  localparam int NREQ    = 2;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]           up_req_valid, up_req_ready, up_resp_valid, up_resp_ready;
  hpdcache_mem_req_t    up_req [2];
  hpdcache_mem_resp_r_t up_resp, mem_resp;
  hpdcache_mem_req_t    mem_req;
  logic                 mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
`ifdef HPDC_MEM_RD_ARB_CHECK_EN
  logic                 err;
`endif

  hpdc_mem_rd_arbiter #(
    .NREQ    (NREQ),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .up_req_valid_i   (up_req_valid),
    .up_req_ready_o   (up_req_ready),
    .up_req_i         (up_req),
    .up_resp_valid_o  (up_resp_valid),
    .up_resp_ready_i  (up_resp_ready),
    .up_resp_o        (up_resp),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_o        (mem_req),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_ready_o (mem_resp_ready),
    .mem_resp_i       (mem_resp)
`ifdef HPDC_MEM_RD_ARB_CHECK_EN
    ,
    .err_o            (err)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: outstanding reads per requester, rotation start, and the
  // requester whose offered read was not yet taken (-1 when none).
  int   m_cnt [2];
  int   m_ptr;
  int   m_pend;
  int   e_win, e_dec;
  logic e_acc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic hpdcache_mem_req_t rand_req();
    hpdcache_mem_req_t r;
    r.mem_req_addr      = $urandom;
    r.mem_req_len       = 8'($urandom);
    r.mem_req_size      = 3'($urandom);
    r.mem_req_id        = 8'($urandom);
    r.mem_req_cacheable = 1'($urandom);
    return r;
  endfunction

  function automatic int model_winner();
    int j;
    if (m_pend >= 0) return m_pend;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (up_req_valid[j] && (m_cnt[j] < MAX_OUT)) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cnt  = '{0, 0};
    m_ptr  = 0;
    m_pend = -1;
  endtask

  task automatic idle();
    up_req_valid   = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    up_resp_ready  = '0;
    mem_resp       = '0;
  endtask

  task automatic eval();
    hpdcache_mem_req_t    er;
    hpdcache_mem_resp_r_t ep;
    logic [1:0]           erdy, ersp;
    int                   ridx;
    #1;
    e_win = model_winner();
    check_eq("mem_req_valid", 128'(mem_req_valid), 128'(e_win >= 0));
    erdy = '0;
    if (e_win >= 0) begin
      er               = up_req[e_win];
      er.mem_req_id[7] = e_win[0];
      check_eq("mem_req", 128'(mem_req), 128'(er));
      if (mem_req_ready) erdy[e_win] = 1'b1;
    end
    e_acc = (e_win >= 0) && mem_req_ready;
    check_eq("up_req_ready", 128'(up_req_ready), 128'(erdy));
    ridx = mem_resp.mem_resp_r_id[7] ? 1 : 0;
    ersp = '0;
    if (mem_resp_valid) ersp[ridx] = 1'b1;
    check_eq("up_resp_valid", 128'(up_resp_valid), 128'(ersp));
    check_eq("mem_resp_ready", 128'(mem_resp_ready), 128'(up_resp_ready[ridx]));
    ep                  = mem_resp;
    ep.mem_resp_r_id[7] = 1'b0;
    check_eq("up_resp", 128'(up_resp), 128'(ep));
    e_dec = (mem_resp_valid && up_resp_ready[ridx] && mem_resp.mem_resp_r_last) ? ridx : -1;
  endtask

  task automatic advance();
    logic inc, dec;
    @(posedge clk);
    if (e_win >= 0) begin
      if (mem_req_ready) begin
        m_pend = -1;
        m_ptr  = (e_win + 1) % NREQ;
      end else begin
        m_pend = e_win;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      inc = e_acc && (e_win == i);
      dec = (e_dec == i);
      if (inc && !dec && (m_cnt[i] < MAX_OUT)) m_cnt[i]++;
      else if (dec && !inc && (m_cnt[i] > 0)) m_cnt[i]--;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    eval();
    advance();
  endtask

  task automatic last_beat_to(input int r);
    mem_resp_valid                = 1'b1;
    mem_resp.mem_resp_r_id        = {r[0], 7'($urandom)};
    mem_resp.mem_resp_r_data      = {$urandom, $urandom};
    mem_resp.mem_resp_r_last      = 1'b1;
    up_resp_ready                 = '0;
    up_resp_ready[r]              = 1'b1;
  endtask

  initial begin
    int b;
    hpdcache_mem_req_t r1;

    // Reset with every input asserted: all handshake outputs must stay low.
    rst = 1'b1;
    idle();
    up_req[0]      = rand_req();
    up_req[1]      = rand_req();
    up_req_valid   = 2'b11;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    up_resp_ready  = 2'b11;
    #3;
    check_eq("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    check_eq("rst_up_req_ready", 128'(up_req_ready), 128'(0));
    check_eq("rst_up_resp_valid", 128'(up_resp_valid), 128'(0));
    check_eq("rst_mem_resp_ready", 128'(mem_resp_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    idle();
    model_reset();

    // Both requesters, downstream always ready: req0 then req1 with tagged IDs.
    up_req[0].mem_req_id = 8'h05;
    up_req[1].mem_req_id = 8'h05;
    up_req_valid         = 2'b11;
    mem_req_ready        = 1'b1;
    eval();
    check_eq("t1_id_req0", 128'(mem_req.mem_req_id), 128'(8'h05));
    advance();
    eval();
    check_eq("t1_id_req1", 128'(mem_req.mem_req_id), 128'(8'h85));
    advance();

    // req1 held for three stalled cycles while req0 arrives; req0 follows the handshake.
    idle();
    r1                   = rand_req();
    r1.mem_req_id        = 8'h2a;
    up_req[1]            = r1;
    up_req[0]            = rand_req();
    up_req_valid         = 2'b10;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) up_req_valid[0] = 1'b1;
      if (c >= 3) mem_req_ready = 1'b1;
      if (c == 4) up_req_valid[1] = 1'b0;
      eval();
      if (c < 4) check_eq("t2_hold_id", 128'(mem_req.mem_req_id), 128'(8'haa));
      else       check_eq("t2_req0_next", 128'(up_req_ready), 128'(2'b01));
      advance();
    end

    // req0 fills to MAX_OUT, gets blocked, req1 still served, a last beat frees req0.
    idle();
    up_req_valid  = 2'b01;
    mem_req_ready = 1'b1;
    cycle();
    cycle();
    eval();
    check_eq("t3_block", 128'(mem_req_valid), 128'(0));
    advance();
    up_req_valid = 2'b11;
    eval();
    check_eq("t3_other", 128'(up_req_ready), 128'(2'b10));
    advance();
    up_req_valid = 2'b01;
    last_beat_to(0);
    eval();
    check_eq("t3_still_block", 128'(up_req_ready), 128'(2'b00));
    advance();
    mem_resp_valid = 1'b0;
    eval();
    check_eq("t3_freed", 128'(up_req_ready), 128'(2'b01));
    advance();

    // Eight-beat burst to requester 1 with toggling ready; only the last beat retires a read.
    idle();
    b = 0;
    mem_resp_valid = 1'b1;
    mem_resp       = '0;
    for (int c = 0; c < 16; c++) begin
      mem_resp.mem_resp_r_id   = 8'h83;
      mem_resp.mem_resp_r_last = (b == 7);
      if (c == 0 || up_resp_ready[1]) mem_resp.mem_resp_r_data = {$urandom, $urandom};
      up_resp_ready = (c % 2 == 1) ? 2'b10 : 2'b00;
      eval();
      check_eq("t4_resp_id", 128'(up_resp.mem_resp_r_id), 128'(8'h03));
      if (up_resp_ready[1]) b++;
      advance();
    end
    check_eq("t4_beats", 128'(b), 128'(8));
    idle();
    up_req_valid  = 2'b10;
    mem_req_ready = 1'b1;
    cycle();
    cycle();
    eval();
    check_eq("t4_req1_full", 128'(up_req_ready), 128'(2'b00));
    advance();

    // Simultaneous accept and last beat on req0 leaves its count unchanged.
    idle();
    last_beat_to(0);
    cycle();
    cycle();
    up_req_valid  = 2'b01;
    mem_req_ready = 1'b1;
    cycle();
    mem_resp_valid = 1'b0;
    cycle();
    cycle();
    eval();
    check_eq("t5_cnt_kept", 128'(up_req_ready), 128'(2'b00));
    advance();

    // Asynchronous reset during HOLD.
    idle();
    up_req[1]     = rand_req();
    up_req_valid  = 2'b10;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_valid_drop", 128'(mem_req_valid), 128'(0));
    check_eq("t6_ready_drop", 128'(up_req_ready), 128'(0));
    model_reset();
    @(negedge clk);
    rst           = 1'b0;
    up_req_valid  = 2'b11;
    mem_req_ready = 1'b1;
    eval();
    check_eq("t6_first", 128'(up_req_ready), 128'(2'b01));
    advance();

    // Random traffic against the model.
    idle();
    cycle();
    for (int c = 0; c < 400; c++) begin
      int r;
      for (int i = 0; i < NREQ; i++) begin
        if (i != m_pend) begin
          up_req_valid[i] = ($urandom_range(0, 2) != 0);
          up_req[i]       = rand_req();
        end
      end
      mem_req_ready = ($urandom_range(0, 2) != 0);
      r = -1;
      if (m_cnt[0] > 0 && m_cnt[1] > 0) r = $urandom_range(0, 1);
      else if (m_cnt[0] > 0)            r = 0;
      else if (m_cnt[1] > 0)            r = 1;
      if (r >= 0 && $urandom_range(0, 1) == 1) begin
        mem_resp_valid           = 1'b1;
        mem_resp.mem_resp_r_id   = {r[0], 7'($urandom)};
        mem_resp.mem_resp_r_data = {$urandom, $urandom};
        mem_resp.mem_resp_r_error = 2'($urandom);
        mem_resp.mem_resp_r_last = ($urandom_range(0, 2) == 0);
      end else begin
        mem_resp_valid = 1'b0;
      end
      up_resp_ready = 2'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
